// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial receive path.
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/shift_receiver_parity_accum.sv
// Running XOR of the frame bits; restarts on the first bit of every frame.
module parity_accum (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic start,
    input  logic data_in,
    output logic parity
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= 1'b0;
        end else if (clear) begin
            parity <= 1'b0;
        end else if (enable) begin
            parity <= start ? data_in : (parity ^ data_in);
        end
    end

endmodule

// File: rtl/shift_receiver.sv
// MSB-first serial-to-parallel receiver with a one-word holding register.
// Optional even-parity bit per frame when SHIFT_RECEIVER_PARITY_EN is defined.
//
// state | meaning
// IDLE  | no bits of the current frame held
// RECV  | 1..N-1 bits of the current frame held
module shift_receiver
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err
);

`ifdef SHIFT_RECEIVER_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    // The final frame bit is taken straight from data_in, so only N-1 bits are held.
    localparam int HOLD_W = FRAME_LEN - 1;
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [HOLD_W-1:0]     shreg;
    logic [HOLD_W-1:0]     shreg_shift;
    logic [DATA_WIDTH-1:0] word;
    logic                  take_bit;
    logic                  last_bit;

    assign take_bit = enable && !clear;
    assign last_bit = take_bit && (bit_cnt == LAST_CNT);

    generate
        if (HOLD_W > 1) begin : g_shift_wide
            assign shreg_shift = {shreg[HOLD_W-2:0], data_in};
        end else begin : g_shift_one
            assign shreg_shift = data_in;
        end
    endgenerate

`ifdef SHIFT_RECEIVER_PARITY_EN
    assign word = shreg;
`else
    assign word = {shreg, data_in};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state == RECV);
        if (clear) begin
            state_next = IDLE;
        end else if (take_bit) begin
            state_next = last_bit ? IDLE : RECV;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clear) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (take_bit) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                shreg   <= shreg_shift;
            end

            // A completing frame and an accept in the same cycle hand over without a bubble.
            if (last_bit) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (last_bit && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SHIFT_RECEIVER_PARITY_EN
    logic par_acc;

    parity_accum u_parity_accum (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .enable  (take_bit),
        .start   (bit_cnt == '0),
        .data_in (data_in),
        .parity  (par_acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (clear) begin
            parity_err <= 1'b0;
        end else if (last_bit && (par_acc != data_in)) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver; frames carry a parity bit when SHIFT_RECEIVER_PARITY_EN is defined.
module tb_shift_receiver;

`ifdef SHIFT_RECEIVER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in;
    logic       enable;
    logic       clear;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int vectors    = 0;
    int miscompares = 0;

    shift_receiver #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enable     (enable),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        enable  = 1'b1;
        tick();
        enable  = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] w, input logic p, input int i);
        if (i < 8) return w[7-i];
        return p;
    endfunction

    task automatic send_frame(input logic [7:0] w, input logic p, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            send_bit(frame_bit(w, p, i));
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 ||
            overrun !== 1'b0 || parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h busy=%b ovr=%b perr=%b, required 0/00/0/0/0",
                     out_valid, out_data, busy, overrun, parity_err);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_gapless();
        send_bit(1'b1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL gapless_busy_first: busy=%b, required 1", busy);
        end
        send_frame(8'hA5, ^8'hA5, 1, FLEN - 1);
        vectors++;
        if (out_data !== 8'hA5 || out_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gapless_a5: data=%h valid=%b busy=%b, required a5/1/0", out_data, out_valid, busy);
        end
        accept();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL accept_a5: valid=%b data=%h, required 0/a5", out_valid, out_data);
        end
    endtask

    task automatic test_gaps();
        logic busy_ok;
        busy_ok = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            send_bit(frame_bit(8'h3C, ^8'h3C, i));
            if (i < FLEN - 1) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                tick();
                if (busy !== 1'b1 || out_valid !== 1'b0) busy_ok = 1'b0;
            end
        end
        vectors++;
        if (busy_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_busy: busy or valid wrong mid-frame, required busy=1 valid=0");
        end
        vectors++;
        if (out_data !== 8'h3C || out_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_3c: data=%h valid=%b busy=%b, required 3c/1/0", out_data, out_valid, busy);
        end
        tick();
        vectors++;
        if (out_data !== 8'h3C || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_3c: data=%h valid=%b, required 3c/1", out_data, out_valid);
        end
        accept();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, ^8'h11, 0, FLEN);
        send_frame(8'h22, ^8'h22, 0, FLEN);
        vectors++;
        if (out_data !== 8'h11 || out_valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_drop: data=%h valid=%b ovr=%b, required 11/1/1", out_data, out_valid, overrun);
        end
        accept();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h11) begin
            miscompares++;
            $display("FAIL overrun_clear: ovr=%b valid=%b data=%h, required 0/0/11", overrun, out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, ^8'h11, 0, FLEN);
        send_frame(8'h22, ^8'h22, 0, FLEN - 1);
        out_ready = 1'b1;
        send_bit(frame_bit(8'h22, ^8'h22, FLEN - 1));
        out_ready = 1'b0;
        vectors++;
        if (out_data !== 8'h22 || out_valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL no_bubble_22: data=%h valid=%b ovr=%b, required 22/1/0", out_data, out_valid, overrun);
        end
        accept();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hFF, ^8'hFF, 0, 5);
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b valid=%b data=%h, required 0/0/00", busy, out_valid, out_data);
        end
        tick();
        reset = 1'b1;
        tick();
        send_frame(8'h81, ^8'h81, 0, FLEN - 1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_partial_early: valid=%b, required 0", out_valid);
        end
        send_bit(frame_bit(8'h81, ^8'h81, FLEN - 1));
        vectors++;
        if (out_data !== 8'h81 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_81: data=%h valid=%b, required 81/1", out_data, out_valid);
        end
        accept();
    endtask

    task automatic test_clear();
        send_frame(8'hFF, ^8'hFF, 0, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_busy: busy=%b, required 0", busy);
        end
        send_frame(8'hF0, ^8'hF0, 0, FLEN);
        vectors++;
        if (out_data !== 8'hF0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_f0: data=%h valid=%b, required f0/1", out_data, out_valid);
        end
        accept();
        clear   = 1'b1;
        data_in = 1'b1;
        enable  = 1'b1;
        tick();
        clear   = 1'b0;
        enable  = 1'b0;
        send_frame(8'h0F, ^8'h0F, 0, FLEN - 1);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_enable_early: valid=%b busy=%b, required 0/1", out_valid, busy);
        end
        send_bit(frame_bit(8'h0F, ^8'h0F, FLEN - 1));
        vectors++;
        if (out_data !== 8'h0F || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_enable_0f: data=%h valid=%b, required 0f/1", out_data, out_valid);
        end
        accept();
    endtask

    task automatic test_parity();
        vectors++;
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_idle: perr=%b, required 0", parity_err);
        end
`ifdef SHIFT_RECEIVER_PARITY_EN
        send_frame(8'h07, 1'b1, 0, FLEN);
        vectors++;
        if (out_data !== 8'h07 || parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_good: data=%h perr=%b, required 07/0", out_data, parity_err);
        end
        accept();
        send_frame(8'h07, 1'b0, 0, FLEN);
        vectors++;
        if (out_data !== 8'h07 || out_valid !== 1'b1 || parity_err !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_bad: data=%h valid=%b perr=%b, required 07/1/1", out_data, out_valid, parity_err);
        end
        accept();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (parity_err !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clear: perr=%b, required 0", parity_err);
        end
`endif
    endtask

    initial begin
        reset     = 1'b0;
        data_in   = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_gapless();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_clear();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
